// File: rtl/xor_stream_pkg.sv
// xor_stream_pkg: shared types and helpers for xor_stream_unit.
//   mode_e      - per-frame operating mode (PAIR / ACCUM)
//   state_e     - frame-tracking FSM states
//   xor_parity_c#(W)::xor_parity(v) - XOR-reduction of a W-bit vector
package xor_stream_pkg;

    typedef enum logic {
        MODE_PAIR  = 1'b0,
        MODE_ACCUM = 1'b1
    } mode_e;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_FRAME = 1'b1
    } state_e;

    // Width-generic parity helper; the class only carries the parameter.
    virtual class xor_parity_c #(parameter int unsigned W = 8);
        static function logic xor_parity(input logic [W-1:0] v);
            return ^v;
        endfunction
    endclass

endpackage

// File: rtl/xor_stream_if.sv
// xor_stream_if: handshake bundle between the stimulus source and
// xor_stream_unit.
//   in_valid/in_ready   - input beat handshake
//   a, b                - WIDTH-bit operands
//   mode, in_last       - frame mode (first beat only) and frame end marker
//   out_valid/out_ready - result handshake
//   c, parity, count    - result, XOR-reduction of c, beats folded into c
interface xor_stream_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 8
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             mode;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] c;
    logic             parity;
    logic [CNT_W-1:0] count;

    // Stimulus / consumer side.
    modport master (
        output in_valid, a, b, mode, in_last, out_ready,
        input  in_ready, out_valid, c, parity, count
    );

    // Block side.
    modport slave (
        input  in_valid, a, b, mode, in_last, out_ready,
        output in_ready, out_valid, c, parity, count
    );
endinterface

// File: rtl/xor_out_stage.sv
// xor_out_stage: single output register for xor_stream_unit.
//   clk, rst_n   - clock, async active-low reset
//   load         - a result is produced this cycle
//   load_c       - result value to register
//   load_count   - beat count to register
//   out_ready    - consumer accepts the held result
//   out_valid, c, parity, count - registered result
//   in_ready     - upstream may present a beat (no skid buffer)
module xor_out_stage
    import xor_stream_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_c,
    input  logic [CNT_W-1:0] load_count,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] c,
    output logic             parity,
    output logic [CNT_W-1:0] count,
    output logic             in_ready
);

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] c_q, c_d;
    logic             parity_q, parity_d;
    logic [CNT_W-1:0] count_q, count_d;

    assign in_ready = !out_valid_q || out_ready;

    always_comb begin
        out_valid_d = out_valid_q;
        c_d         = c_q;
        parity_d    = parity_q;
        count_d     = count_q;
        if (load) begin
            // Load wins over consume so back-to-back results have no bubble.
            out_valid_d = 1'b1;
            c_d         = load_c;
            parity_d    = xor_parity_c#(WIDTH)::xor_parity(load_c);
            count_d     = load_count;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            c_q         <= '0;
            parity_q    <= 1'b0;
            count_q     <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            c_q         <= c_d;
            parity_q    <= parity_d;
            count_q     <= count_d;
        end
    end

    assign out_valid = out_valid_q;
    assign c         = c_q;
    assign parity    = parity_q;
    assign count     = count_q;

endmodule

// File: rtl/xor_stream_unit.sv
// xor_stream_unit: handshaked bitwise XOR of two operands, per beat (PAIR)
// or as a running XOR over a multi-beat frame (ACCUM).
//   clk, rst_n - clock, async active-low reset
//   bus        - xor_stream_if slave: input beat handshake, operands,
//                mode/in_last, and the registered result with parity/count
module xor_stream_unit
    import xor_stream_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 8
) (
    input logic         clk,
    input logic         rst_n,
    xor_stream_if.slave bus
);

    state_e           state_q, state_d;
    mode_e            fm_q, fm_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             in_ready;
    logic             accept;
    logic [WIDTH-1:0] ab;
    logic [CNT_W-1:0] cnt_inc;
    mode_e            eff_mode;
    logic             load;
    logic [WIDTH-1:0] load_c;

    assign accept   = bus.in_valid && in_ready;
    // Operands are masked unless a beat is taken, so idle-bus X never reaches state.
    assign ab       = accept ? (bus.a ^ bus.b) : '0;
    assign cnt_inc  = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
    // Mode only matters on the first beat; inside a frame the latched mode rules.
    assign eff_mode = (state_q == S_FRAME) ? fm_q : mode_e'(bus.mode);
    assign load_c   = acc_q ^ ab;

    // acc_q and cnt_q are always zero in S_IDLE, so the same fold
    // (acc^a^b, cnt+1) serves both single-beat results and frame ends.
    always_comb begin
        state_d = state_q;
        fm_d    = fm_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        load    = 1'b0;
        if (accept) begin
            if (eff_mode == MODE_PAIR || bus.in_last) begin
                load    = 1'b1;
                state_d = S_IDLE;
                fm_d    = MODE_PAIR;
                acc_d   = '0;
                cnt_d   = '0;
            end else begin
                state_d = S_FRAME;
                fm_d    = MODE_ACCUM;
                acc_d   = load_c;
                cnt_d   = cnt_inc;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            fm_q    <= MODE_PAIR;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            fm_q    <= fm_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
        end
    end

    xor_out_stage #(
        .WIDTH(WIDTH),
        .CNT_W(CNT_W)
    ) u_out (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .load_c    (load_c),
        .load_count(cnt_inc),
        .out_ready (bus.out_ready),
        .out_valid (bus.out_valid),
        .c         (bus.c),
        .parity    (bus.parity),
        .count     (bus.count),
        .in_ready  (in_ready)
    );

    assign bus.in_ready = in_ready;

endmodule
